// File: rtl/cave_input_pkg.sv
// Shared constants for the cave player-input front end: joystick word layout
// and the fixed PS/2 keymaps for the two keyboard-mapped players.
package cave_input_pkg;

   localparam int JOY_RIGHT   = 0;
   localparam int JOY_LEFT    = 1;
   localparam int JOY_DOWN    = 2;
   localparam int JOY_UP      = 3;
   localparam int JOY_BTN0    = 4;
   localparam int JOY_START   = 10;
   localparam int JOY_COIN    = 11;
   localparam int JOY_PAUSE   = 12;
   localparam int JOY_SERVICE = 13;
   localparam int JOY_USED    = 14;

   typedef struct packed {
      logic       ext;
      logic [7:0] code;
   } keymap_t;

   // Tables are indexed by joystick bit position, so key state lines up with the joystick word.
   localparam keymap_t P1_KEYMAP [JOY_USED] = '{
      '{1'b1, 8'h74}, '{1'b1, 8'h6B}, '{1'b1, 8'h72}, '{1'b1, 8'h75},
      '{1'b0, 8'h14}, '{1'b0, 8'h11}, '{1'b0, 8'h29}, '{1'b0, 8'h1A},
      '{1'b0, 8'h22}, '{1'b0, 8'h21}, '{1'b0, 8'h16}, '{1'b0, 8'h2E},
      '{1'b0, 8'h4D}, '{1'b0, 8'h46}
   };
   localparam logic [JOY_USED-1:0] P1_MAPPED = 14'h3FFF;

   localparam keymap_t P2_KEYMAP [JOY_USED] = '{
      '{1'b0, 8'h34}, '{1'b0, 8'h23}, '{1'b0, 8'h2B}, '{1'b0, 8'h2D},
      '{1'b0, 8'h1C}, '{1'b0, 8'h1B}, '{1'b0, 8'h15}, '{1'b0, 8'h1D},
      '{1'b0, 8'h24}, '{1'b0, 8'h2C}, '{1'b0, 8'h1E}, '{1'b0, 8'h36},
      '{1'b0, 8'h00}, '{1'b0, 8'h45}
   };
   // Player 2 has no pause key.
   localparam logic [JOY_USED-1:0] P2_MAPPED = 14'h2FFF;

   function automatic logic key_hit(input keymap_t m, input logic used,
                                    input logic ext, input logic [7:0] code);
      return used && (m.ext == ext) && (m.code == code);
   endfunction

endpackage

// File: rtl/cave_coin_stretch.sv
// Coin pulse stretcher: a rising edge of raw reloads a down-counter and the
// output stays high while raw is high or the counter is nonzero.
module cave_coin_stretch
   import cave_input_pkg::*;
#(
   parameter int unsigned COIN_PULSE = 16'd1024
) (
   input  logic clk_sys,
   input  logic rst_sys_n,
   input  logic raw,
   output logic stretched
);

   localparam int CW = $clog2(COIN_PULSE + 1);

   logic [CW-1:0] cnt;
   logic          raw_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         cnt   <= '0;
         raw_q <= 1'b0;
      end else begin
         raw_q <= raw;
         if (raw && !raw_q)
            cnt <= CW'(COIN_PULSE);
         else if (cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

   assign stretched = raw | (cnt != '0);

endmodule

// File: rtl/cave_input_ctrl.sv
// Player-input front end: PS/2 key decode, keyboard/joystick merge, coin
// stretch and registered outputs. Optional autofire via CAVE_INPUT_AUTOFIRE_EN.
module cave_input_ctrl
   import cave_input_pkg::*;
#(
   parameter int          NUM_PLAYERS  = 2,
   parameter int          NUM_BUTTONS  = 3,
   parameter int unsigned COIN_PULSE   = 16'd1024,
   parameter int unsigned AUTOFIRE_DIV = 20'd400000
) (
   input  logic                             clk_sys,
   input  logic                             rst_sys_n,
   input  logic [10:0]                      ps2_key,
   input  logic [32*NUM_PLAYERS-1:0]        joystick,
   input  logic                             clear_keys,
   input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] autofire_mask,
   output logic [NUM_PLAYERS-1:0]           up,
   output logic [NUM_PLAYERS-1:0]           down,
   output logic [NUM_PLAYERS-1:0]           left,
   output logic [NUM_PLAYERS-1:0]           right,
   output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] buttons,
   output logic [NUM_PLAYERS-1:0]           start,
   output logic [NUM_PLAYERS-1:0]           coin,
   output logic [NUM_PLAYERS-1:0]           pause,
   output logic [NUM_PLAYERS-1:0]           service
);

   localparam int NB = NUM_BUTTONS;

   logic                      old_toggle;
   logic                      prime;
   logic                      key_event;
   logic [1:0][JOY_USED-1:0]  key_state;
   logic [JOY_USED-1:0]       raw [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0]    coin_d;
   logic [NUM_PLAYERS*NB-1:0] btn_raw;
   logic [NUM_PLAYERS*NB-1:0] btn_fire;
   logic [NUM_PLAYERS-1:0]    unused_joy;
   logic                      unused_misc;

   // The first edge after reset only captures the toggle level, so a stale toggle is never seen as an event.
   assign key_event = prime && (ps2_key[10] != old_toggle);

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         old_toggle <= 1'b0;
         prime      <= 1'b0;
         key_state  <= '0;
      end else begin
         old_toggle <= ps2_key[10];
         prime      <= 1'b1;
         if (clear_keys) begin
            key_state <= '0;
         end else if (key_event) begin
            for (int k = 0; k < JOY_USED; k++) begin
               if (key_hit(P1_KEYMAP[k], P1_MAPPED[k], ps2_key[8], ps2_key[7:0]))
                  key_state[0][k] <= ps2_key[9];
               if (key_hit(P2_KEYMAP[k], P2_MAPPED[k], ps2_key[8], ps2_key[7:0]))
                  key_state[1][k] <= ps2_key[9];
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      if (p < 2) begin : g_kbd
         assign raw[p] = joystick[32*p +: JOY_USED] | key_state[p];
      end else begin : g_joy_only
         assign raw[p] = joystick[32*p +: JOY_USED];
      end

      assign btn_raw[NB*p +: NB] = raw[p][JOY_BTN0 +: NB];
      assign unused_joy[p]       = ^{joystick[32*p+JOY_USED +: 32-JOY_USED], raw[p]};

      cave_coin_stretch #(.COIN_PULSE(COIN_PULSE)) u_coin (
         .clk_sys   (clk_sys),
         .rst_sys_n (rst_sys_n),
         .raw       (raw[p][JOY_COIN]),
         .stretched (coin_d[p])
      );
   end

`ifdef CAVE_INPUT_AUTOFIRE_EN
   localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

   logic [AW-1:0]             af_cnt;
   logic                      af_phase;
   logic                      af_wrap;
   logic [NUM_PLAYERS*NB-1:0] btn_q;
   logic [NUM_PLAYERS*NB-1:0] af_local;

   assign af_wrap = (af_cnt == AW'(AUTOFIRE_DIV - 1));

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         af_cnt   <= '0;
         af_phase <= 1'b0;
         btn_q    <= '0;
         af_local <= '0;
      end else begin
         af_cnt   <= af_wrap ? '0 : af_cnt + 1'b1;
         af_phase <= af_phase ^ af_wrap;
         btn_q    <= btn_raw;
         for (int i = 0; i < NUM_PLAYERS*NB; i++) begin
            if (btn_raw[i] && !btn_q[i])
               af_local[i] <= 1'b1;
            else if (btn_raw[i] && af_wrap)
               af_local[i] <= ~af_local[i];
         end
      end
   end

   // A fresh press forces the output high on the same cycle the press is seen.
   assign btn_fire    = btn_raw & (~autofire_mask | (btn_raw & ~btn_q) | af_local);
   assign unused_misc = ^{key_state, af_phase};
`else
   assign btn_fire    = btn_raw;
   assign unused_misc = ^{key_state, autofire_mask};
`endif

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         up      <= '0;
         down    <= '0;
         left    <= '0;
         right   <= '0;
         start   <= '0;
         coin    <= '0;
         pause   <= '0;
         service <= '0;
         buttons <= '0;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            up[p]      <= raw[p][JOY_UP];
            down[p]    <= raw[p][JOY_DOWN];
            left[p]    <= raw[p][JOY_LEFT];
            right[p]   <= raw[p][JOY_RIGHT];
            start[p]   <= raw[p][JOY_START];
            pause[p]   <= raw[p][JOY_PAUSE];
            service[p] <= raw[p][JOY_SERVICE];
         end
         coin    <= coin_d;
         buttons <= btn_fire;
      end
   end

endmodule

// File: tb/tb_cave_input_ctrl.sv
// Scoreboard bench for cave_input_ctrl: the driver queues per-cycle expected
// output vectors, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_cave_input_ctrl;

   localparam int          NP = 4;
   localparam int          NB = 6;
   localparam int unsigned CP = 8;
   localparam int unsigned AD = 4;

   logic                clk_sys = 1'b0;
   logic                rst_sys_n = 1'b0;
   logic [10:0]         ps2_key;
   logic [32*NP-1:0]    joystick;
   logic                clear_keys;
   logic [NP*NB-1:0]    autofire_mask;
   logic [NP-1:0]       up, down, left, right, start, coin, pause, service;
   logic [NP*NB-1:0]    buttons;

   typedef struct packed {
      logic [NP-1:0]    service;
      logic [NP-1:0]    pause;
      logic [NP-1:0]    coin;
      logic [NP-1:0]    start;
      logic [NP*NB-1:0] buttons;
      logic [NP-1:0]    right;
      logic [NP-1:0]    left;
      logic [NP-1:0]    down;
      logic [NP-1:0]    up;
   } outs_t;

   typedef struct {
      int    cyc;
      outs_t exp;
      string name;
   } exp_t;

   exp_t  sb[$];
   outs_t got;
   int    cyc = 0;
   int    rel_cyc = 0;
   int    n_vec = 0;
   int    n_err = 0;
   bit    tog = 1'b1;

   cave_input_ctrl #(
      .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .COIN_PULSE(CP), .AUTOFIRE_DIV(AD)
   ) dut (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .ps2_key(ps2_key),
      .joystick(joystick), .clear_keys(clear_keys), .autofire_mask(autofire_mask),
      .up(up), .down(down), .left(left), .right(right), .buttons(buttons),
      .start(start), .coin(coin), .pause(pause), .service(service)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   always_comb begin
      got         = '0;
      got.service = service;
      got.pause   = pause;
      got.coin    = coin;
      got.start   = start;
      got.buttons = buttons;
      got.right   = right;
      got.left    = left;
      got.down    = down;
      got.up      = up;
   end

   task automatic check(input exp_t e);
      n_vec++;
      if (e.cyc != cyc) begin
         n_err++;
         $display("FAIL %s: vector for cycle %0d never compared (now %0d)", e.name, e.cyc, cyc);
      end else if (got !== e.exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", e.name, cyc, got, e.exp);
      end
   endtask

   always @(negedge clk_sys) begin : monitor
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc <= cyc) begin
            check(sb[i]);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic expect_at(input int k, input outs_t e, input string nm);
      exp_t item;
      item.cyc  = cyc + k;
      item.exp  = e;
      item.name = nm;
      sb.push_back(item);
   endtask

   task automatic expect_quiet(input int from, input int to, input string nm);
      for (int k = from; k <= to; k++) expect_at(k, '0, nm);
   endtask

   task automatic key_evt(input bit pressed, input bit ext, input logic [7:0] code);
      tog     = ~tog;
      ps2_key = {tog, pressed, ext, code};
   endtask

   initial begin
      outs_t e;
      ps2_key       = {1'b1, 1'b1, 1'b1, 8'h75};
      joystick      = '0;
      clear_keys    = 1'b0;
      autofire_mask = '0;

      tick(3);
      expect_quiet(1, 1, "reset");
      tick(1);
      rst_sys_n = 1'b1;
      rel_cyc   = cyc;
      expect_quiet(1, 4, "prime_no_key");
      tick(4);

      // Extended 75 is player 1 up
      key_evt(1'b1, 1'b1, 8'h75);
      e = '0; e.up[0] = 1'b1;
      expect_quiet(1, 1, "up_latency");
      expect_at(2, e, "up_press");
      expect_at(3, e, "up_hold");
      tick(4);
      key_evt(1'b0, 1'b1, 8'h75);
      expect_at(1, e, "up_rel_latency");
      expect_at(2, '0, "up_release");
      tick(4);

      // Bare 75 is not mapped
      key_evt(1'b1, 1'b0, 8'h75);
      expect_quiet(1, 3, "bare_75");
      tick(4);
      key_evt(1'b0, 1'b0, 8'h75);
      tick(3);

      // Player 2 start via keyboard, player 1 left via joystick OR keyboard
      key_evt(1'b1, 1'b0, 8'h1E);
      joystick[1] = 1'b1;
      e = '0; e.left[0] = 1'b1;
      expect_at(1, e, "joy_left");
      e.start[1] = 1'b1;
      expect_at(2, e, "p2_start_key");
      tick(2);
      joystick[1] = 1'b0;
      key_evt(1'b0, 1'b0, 8'h1E);
      e = '0; e.start[1] = 1'b1;
      expect_at(1, e, "p2_start_hold");
      expect_at(2, '0, "p2_start_rel");
      tick(4);

      // Single-cycle coin: 9 cycles high
      joystick[11] = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         e = '0; e.coin[0] = (k <= 9);
         expect_at(k, e, "coin_pulse");
      end
      tick(1);
      joystick[11] = 1'b0;
      tick(12);

      // Held coin: exactly the hold duration
      joystick[11] = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         e = '0; e.coin[0] = (k <= 20);
         expect_at(k, e, "coin_held");
      end
      tick(20);
      joystick[11] = 1'b0;
      tick(4);

      // Re-trigger while stretching reloads the counter
      joystick[11] = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         e = '0; e.coin[0] = (k <= 13);
         expect_at(k, e, "coin_retrig");
      end
      tick(1);
      joystick[11] = 1'b0;
      tick(3);
      joystick[11] = 1'b1;
      tick(1);
      joystick[11] = 1'b0;
      tick(12);

      // Player 4 button 5; bit 14 ignored
      joystick[32*3+9]  = 1'b1;
      joystick[32*3+14] = 1'b1;
      e = '0; e.buttons[23] = 1'b1;
      expect_at(1, e, "p4_btn5");
      tick(1);
      joystick[32*3+9] = 1'b0;
      expect_quiet(1, 2, "p4_bit14");
      tick(3);
      joystick[32*3+14] = 1'b0;

      // clear_keys wins over a same-cycle event
      key_evt(1'b1, 1'b0, 8'h1C);
      clear_keys = 1'b1;
      expect_quiet(1, 3, "clear_vs_event");
      tick(1);
      clear_keys = 1'b0;
      tick(3);
      key_evt(1'b1, 1'b0, 8'h1C);
      e = '0; e.buttons[NB] = 1'b1;
      expect_quiet(1, 1, "key_a_latency");
      expect_at(2, e, "key_a_press");
      expect_at(3, e, "key_a_hold");
      tick(4);
      clear_keys = 1'b1;
      expect_at(1, e, "clear_latency");
      expect_at(2, '0, "clear_drop");
      tick(1);
      clear_keys = 1'b0;
      tick(3);

`ifdef CAVE_INPUT_AUTOFIRE_EN
      begin
         bit lp;
         autofire_mask[0] = 1'b1;
         joystick[4]      = 1'b1;
         e = '0; e.buttons[0] = 1'b1;
         expect_at(1, e, "af_first");
         lp = 1'b1;
         for (int k = 2; k <= 13; k++) begin
            e = '0; e.buttons[0] = lp;
            expect_at(k, e, "af_toggle");
            if (((cyc + k - rel_cyc) % AD) == 0) lp = ~lp;
         end
         tick(13);
         joystick[4] = 1'b0;
         expect_quiet(1, 2, "af_release");
         tick(3);
         autofire_mask[0] = 1'b0;
         joystick[4]      = 1'b1;
         e = '0; e.buttons[0] = 1'b1;
         for (int k = 1; k <= 8; k++) expect_at(k, e, "af_unmasked");
         tick(8);
         joystick[4] = 1'b0;
         expect_quiet(1, 1, "af_unmasked_rel");
         tick(2);
      end
`endif

      for (int t = 0; t < 100 && sb.size() > 0; t++) tick(1);
      while (sb.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: expected vector for cycle %0d left unchecked", sb[0].name, sb[0].cyc);
         sb.delete(0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cave_input_ctrl.md
Name: cave_input_ctrl

Overview:
- Parametrised player-input front end for the cave core; replaces the fixed, two-player inline PS/2 and joystick merge in the emu top level.
- Decodes hps_io ps2_key events into per-key state, and matches the E0 extended flag.
- ORs keyboard state with joystick_N words for 1-4 players and 1-6 buttons.
- Stretches coin pulses to a guaranteed minimum width and registers all outputs toward Main's io_joystick_* ports.

Parameters:
- NUM_PLAYERS, 2, number of players, legal 1..4. Players 3 and 4 are joystick-only.
- NUM_BUTTONS, 3, fire buttons per player, legal 1..6.
- COIN_PULSE, 16'd1024, minimum coin output high time in clk_sys cycles, legal >=1.
- AUTOFIRE_DIV, 20'd400000, autofire half-period in clk_sys cycles (only used with CAVE_INPUT_AUTOFIRE_EN).

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  asynchronous active-low reset
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scancode
- joystick  in  32*NUM_PLAYERS  player p word at [32p+31:32p]
- clear_keys  in  1  synchronous clear of all keyboard state (OSD open / focus loss)
- autofire_mask  in  NUM_PLAYERS*NUM_BUTTONS  per-button autofire select
- up, down, left, right  out  NUM_PLAYERS  directions, bit p = player p
- buttons  out  NUM_PLAYERS*NUM_BUTTONS  player p at [NB*p+NB-1:NB*p]
- start, coin, pause, service  out  NUM_PLAYERS each

Behaviour:
- Reset: all key registers, outputs, coin counters and autofire state are 0. The prime flag is cleared.
- Toggle priming:
  - On the first clk_sys edge after reset release, old_toggle <= ps2_key[10] and prime <= 1. No event is decoded on that edge.
  - After priming, event = (ps2_key[10] != old_toggle), and old_toggle follows ps2_key[10] every cycle.
- On event: the key whose {extended, code} matches exactly gets key <= ps2_key[9].
  - Unmatched codes are ignored.
  - Extended and non-extended forms of one code are distinct keys; e.g. E0 75 is up, bare 75 is not.
- clear_keys has priority over a same-cycle event: all keys go to 0 and the event is dropped.
- Joystick word layout:
  - [0] right, [1] left, [2] down, [3] up.
  - [4+i] button i, for i=0..5.
  - [10] start, [11] coin, [12] pause, [13] service.
  - Bits >=14 are ignored. Buttons >= NUM_BUTTONS are ignored.
- raw_x = key_x | joystick bit. Every output is registered.
- Latency: joystick change to output = 1 cycle. ps2_key toggle to output = 2 cycles (key register, then output register).
- Coin, per player, counter width $clog2(COIN_PULSE+1):
  - A rising edge of raw_coin loads the counter with COIN_PULSE.
  - Otherwise the counter decrements while nonzero, saturating at 0.
  - coin = raw_coin | (cnt != 0).
  - A re-trigger while stretching reloads the counter.
  - A held raw_coin keeps coin high for the full hold duration.
- Players >=2 have no keyboard mapping; their outputs are the joystick bits only.

Optional Feature:
- Macro: CAVE_INPUT_AUTOFIRE_EN.
- When defined:
  - A shared free-running counter wraps at AUTOFIRE_DIV-1 and toggles a phase bit on wrap.
  - For each masked button, a rising edge of raw latches local phase = 1.
  - The local phase then toggles on each wrap while raw is held, and the output is raw & local phase. The first press is therefore high immediately.
  - On release, the output goes to 0 on the next cycle.
  - Unmasked buttons pass raw unchanged.
- When undefined: autofire_mask is ignored, the autofire counter is absent, and buttons = registered raw.

Decomposition:
- Package cave_input_pkg holds:
  - Joystick bit-index localparams (JOY_RIGHT..JOY_SERVICE, JOY_BTN0).
  - The keymap struct typedef {logic ext; logic [7:0] code;}.
  - Constant keymap tables for P1 and P2.
- P1 keymap: up E0 75, down E0 72, left E0 6B, right E0 74; buttons 14, 11, 29, 1A, 22, 21; start 16; coin 2E; pause 4D; service 46.
- P2 keymap: up 2D, down 2B, left 23, right 34; buttons 1C, 1B, 15, 1D, 24, 2C; start 1E; coin 36; pause none; service 45.
- One sub-module, cave_coin_stretch: a single counter instance, generated per player.

Test Plan:
- Reset with ps2_key[10]=1, release: no key set. Then toggle ps2_key[10] to 0 with {pressed=1, ext=1, code=75}: up[0]=1 exactly 2 cycles later. Release event: up[0]=0.
- ps2_key {pressed=1, ext=0, code=75}: all outputs stay 0 (keypad 8 is not mapped).
- COIN_PULSE=8: joystick[11] high for 1 cycle gives coin[0] high for 9 cycles. Held 20 cycles gives 20 cycles high. Re-pulse after 4 cycles extends the end to 8 cycles after the re-pulse.
- NUM_PLAYERS=4, NUM_BUTTONS=6: joystick[32*3+9]=1 gives buttons[23]=1 one cycle later. joystick[32*3+14] has no effect.
- Key A (1C) pressed together with clear_keys=1 on the same cycle: buttons[NB]=0. A held key followed by clear_keys pulse: the output drops 2 cycles later.
- With CAVE_INPUT_AUTOFIRE_EN, AUTOFIRE_DIV=4, mask bit 0 set, joystick[4] held: buttons[0] reads 1 then toggles every 4 cycles. Mask bit 0 cleared: buttons[0] stays steady high.
